// File: rtl/rob_commit_queue_if.sv
// Bus bundle for rob_commit_queue: issue, operand query, two writeback ports, commit/flush.
// With ROB_PERF_CNT_EN defined the bundle also carries the commit/mispredict counters.
interface rob_commit_queue_if #(
  parameter int unsigned BITS = 3,
  parameter int unsigned XLEN = 32
);
  logic            issue_valid;
  logic [2:0]      issue_kind;
  logic [4:0]      issue_rd;
  logic [XLEN-1:0] issue_pc;
  logic            issue_pred;
  logic [XLEN-1:0] issue_alt_pc;
  logic            full;
  logic [BITS-1:0] rob_tail;
  logic            stall;

  logic [BITS-1:0] q_id_1;
  logic [BITS-1:0] q_id_2;
  logic            q_ready_1;
  logic            q_ready_2;
  logic [XLEN-1:0] q_value_1;
  logic [XLEN-1:0] q_value_2;

  logic            wb0_valid;
  logic [BITS-1:0] wb0_id;
  logic [XLEN-1:0] wb0_value;
  logic            wb1_valid;
  logic [BITS-1:0] wb1_id;
  logic [XLEN-1:0] wb1_value;

  logic            commit_we;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_value;
  logic [BITS-1:0] commit_id;
  logic            commit_store;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]     perf_commits;
  logic [31:0]     perf_mispredicts;
`endif

  modport master (
    output issue_valid, issue_kind, issue_rd, issue_pc, issue_pred, issue_alt_pc,
    output q_id_1, q_id_2,
    output wb0_valid, wb0_id, wb0_value, wb1_valid, wb1_id, wb1_value,
    input  full, rob_tail, stall, q_ready_1, q_ready_2, q_value_1, q_value_2,
    input  commit_we, commit_rd, commit_value, commit_id, commit_store, flush, redirect_pc
`ifdef ROB_PERF_CNT_EN
    , input perf_commits, perf_mispredicts
`endif
  );

  modport slave (
    input  issue_valid, issue_kind, issue_rd, issue_pc, issue_pred, issue_alt_pc,
    input  q_id_1, q_id_2,
    input  wb0_valid, wb0_id, wb0_value, wb1_valid, wb1_id, wb1_value,
    output full, rob_tail, stall, q_ready_1, q_ready_2, q_value_1, q_value_2,
    output commit_we, commit_rd, commit_value, commit_id, commit_store, flush, redirect_pc
`ifdef ROB_PERF_CNT_EN
    , output perf_commits, perf_mispredicts
`endif
  );
endinterface

// File: rtl/rob_commit_queue.sv
// Reorder buffer: in-order allocate, dual writeback, operand lookup, single retire with flush on redirect.
// Optional ROB_PERF_CNT_EN adds free-running retire and flush counters.
module rob_commit_queue #(
  parameter int unsigned BITS = 3,
  parameter int unsigned XLEN = 32
) (
  input logic              clk_in,
  input logic              rst_in,
  input logic              rdy_in,
  rob_commit_queue_if.slave rob
);
  localparam int unsigned SIZE = 2 ** BITS;
  localparam int unsigned CW   = BITS + 1;

  typedef enum logic [2:0] {
    K_ALU    = 3'd0,
    K_LOAD   = 3'd1,
    K_STORE  = 3'd2,
    K_BRANCH = 3'd3,
    K_JAL    = 3'd4,
    K_JALR   = 3'd5
  } kind_e;

  // value holds the result (link address for JAL/JALR, taken bit for BRANCH); addr the redirect target
  typedef struct packed {
    logic            busy;
    logic            ready;
    kind_e           kind;
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] addr;
    logic            pred;
  } entry_t;

  entry_t          ent_q [SIZE];
  logic [BITS-1:0] head_q;
  logic [BITS-1:0] tail_q;
  logic [CW-1:0]   count_q;
  logic            stall_q;

  logic            commit_we_q;
  logic [4:0]      commit_rd_q;
  logic [XLEN-1:0] commit_value_q;
  logic [BITS-1:0] commit_id_q;
  logic            commit_store_q;
  logic            flush_q;
  logic [XLEN-1:0] redirect_q;

  entry_t          head_c;
  entry_t          new_c;
  kind_e           issue_kind_c;
  logic            full_c;
  logic            retire_c;
  logic            flush_c;
  logic            issue_c;
  logic            commit_we_c;
  logic            wb_ok_c  [2];
  logic [BITS-1:0] wb_id_c  [2];
  logic [XLEN-1:0] wb_val_c [2];

  assign head_c       = ent_q[head_q];
  assign full_c       = (count_q == CW'(SIZE));
  assign issue_kind_c = (rob.issue_kind > 3'd5) ? K_ALU : kind_e'(rob.issue_kind);

  // Head retires once busy & ready; JALR and a mispredicted BRANCH also flush everything.
  assign retire_c = rdy_in && head_c.busy && head_c.ready;
  assign flush_c  = retire_c &&
                    ((head_c.kind == K_JALR) ||
                     ((head_c.kind == K_BRANCH) && (head_c.value[0] != head_c.pred)));
  assign issue_c  = rdy_in && rob.issue_valid && !full_c && !flush_c;
  assign commit_we_c = retire_c && (head_c.rd != 5'd0) &&
                       (head_c.kind inside {K_ALU, K_LOAD, K_JAL, K_JALR});

  assign wb_id_c[0]  = rob.wb0_id;
  assign wb_id_c[1]  = rob.wb1_id;
  assign wb_val_c[0] = rob.wb0_value;
  assign wb_val_c[1] = rob.wb1_value;

  // A writeback lands only on a busy, still-pending entry; port 0 owns a shared target.
  assign wb_ok_c[0] = rdy_in && !flush_c && rob.wb0_valid &&
                      ent_q[rob.wb0_id].busy && !ent_q[rob.wb0_id].ready;
  assign wb_ok_c[1] = rdy_in && !flush_c && rob.wb1_valid &&
                      ent_q[rob.wb1_id].busy && !ent_q[rob.wb1_id].ready &&
                      !(rob.wb0_valid && (rob.wb0_id == rob.wb1_id));

  // Entry image written at the tail on issue
  always_comb begin
    new_c      = '0;
    new_c.busy = 1'b1;
    new_c.kind = issue_kind_c;
    new_c.rd   = rob.issue_rd;
    case (issue_kind_c)
      K_JAL: begin
        new_c.ready = 1'b1;
        new_c.value = rob.issue_pc + XLEN'(4);
      end
      K_JALR:   new_c.value = rob.issue_pc + XLEN'(4);
      K_BRANCH: begin
        new_c.addr = rob.issue_alt_pc;
        new_c.pred = rob.issue_pred;
      end
      default: ;
    endcase
  end

  function automatic logic [XLEN:0] lookup(
    input entry_t          e,
    input logic [BITS-1:0] qid,
    input logic            ok0,
    input logic [BITS-1:0] id0,
    input logic [XLEN-1:0] v0,
    input logic            ok1,
    input logic [BITS-1:0] id1,
    input logic [XLEN-1:0] v1
  );
    logic [XLEN:0] r;
    r = {1'b0, e.value};
    if (ok0 && (id0 == qid))      r = {1'b1, v0};
    else if (ok1 && (id1 == qid)) r = {1'b1, v1};
    else if (e.busy && e.ready)   r = {1'b1, e.value};
    return r;
  endfunction

  assign {rob.q_ready_1, rob.q_value_1} = lookup(ent_q[rob.q_id_1], rob.q_id_1,
      wb_ok_c[0], wb_id_c[0], wb_val_c[0], wb_ok_c[1], wb_id_c[1], wb_val_c[1]);
  assign {rob.q_ready_2, rob.q_value_2} = lookup(ent_q[rob.q_id_2], rob.q_id_2,
      wb_ok_c[0], wb_id_c[0], wb_val_c[0], wb_ok_c[1], wb_id_c[1], wb_val_c[1]);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(SIZE); i++) ent_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      stall_q        <= 1'b0;
      commit_we_q    <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_id_q    <= '0;
      commit_store_q <= 1'b0;
      flush_q        <= 1'b0;
      redirect_q     <= '0;
    end else if (rdy_in) begin
      commit_we_q    <= commit_we_c;
      commit_store_q <= retire_c && (head_c.kind == K_STORE);
      flush_q        <= flush_c;
      if (retire_c) begin
        commit_rd_q    <= head_c.rd;
        commit_value_q <= head_c.value;
        commit_id_q    <= head_q;
      end
      if (flush_c) begin
        redirect_q <= head_c.addr;
        for (int i = 0; i < int'(SIZE); i++) begin
          ent_q[i].busy  <= 1'b0;
          ent_q[i].ready <= 1'b0;
        end
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        stall_q <= 1'b0;
      end else begin
        if (retire_c) begin
          ent_q[head_q].busy  <= 1'b0;
          ent_q[head_q].ready <= 1'b0;
          head_q              <= head_q + BITS'(1);
        end
        for (int p = 0; p < 2; p++) begin
          if (wb_ok_c[p]) begin
            ent_q[wb_id_c[p]].ready <= 1'b1;
            case (ent_q[wb_id_c[p]].kind)
              K_BRANCH: ent_q[wb_id_c[p]].value <= XLEN'(wb_val_c[p][0]);
              K_JALR:   ent_q[wb_id_c[p]].addr  <= wb_val_c[p];
              default:  ent_q[wb_id_c[p]].value <= wb_val_c[p];
            endcase
          end
        end
        if (issue_c) begin
          ent_q[tail_q] <= new_c;
          tail_q        <= tail_q + BITS'(1);
          if (issue_kind_c == K_JALR) stall_q <= 1'b1;
        end
        count_q <= count_q + CW'(issue_c) - CW'(retire_c);
      end
    end else begin
      commit_we_q    <= 1'b0;
      commit_store_q <= 1'b0;
      flush_q        <= 1'b0;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commits_q;
  logic [31:0] perf_mispredicts_q;

  // Cleared only by reset; a flush leaves the history intact
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      perf_commits_q     <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_commits_q     <= perf_commits_q + 32'(retire_c);
      perf_mispredicts_q <= perf_mispredicts_q + 32'(flush_c);
    end
  end

  assign rob.perf_commits     = perf_commits_q;
  assign rob.perf_mispredicts = perf_mispredicts_q;
`endif

  assign rob.full         = full_c;
  assign rob.rob_tail     = tail_q;
  assign rob.stall        = stall_q;
  assign rob.commit_we    = commit_we_q;
  assign rob.commit_rd    = commit_rd_q;
  assign rob.commit_value = commit_value_q;
  assign rob.commit_id    = commit_id_q;
  assign rob.commit_store = commit_store_q;
  assign rob.flush        = flush_q;
  assign rob.redirect_pc  = redirect_q;
endmodule
